// File: rtl/lsu_axi_master_if.sv
// ============================================================================
// Module  : lsu_axi_master_if
// Brief   : Bundles the EXU request/response port and the AXI-lite channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lsu_axi_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic [1:0]        req_size_i;
    logic              req_signed_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;

    logic [ADDR_W-1:0] araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [31:0]       rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [ADDR_W-1:0] awaddr_o;
    logic              awvalid_o;
    logic              awready_i;
    logic [31:0]       wdata_o;
    logic [3:0]        wstrb_o;
    logic              wvalid_o;
    logic              wready_i;
    logic [1:0]        bresp_i;
    logic              bvalid_i;
    logic              bready_o;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_signed_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        input  arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_signed_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        output arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_axi_master.sv
// ============================================================================
// Module  : lsu_axi_master
// Brief   : AXI-lite initiator for EXU loads/stores, one request outstanding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_axi_master #(
    parameter int ADDR_W = 32
) (
    input  wire                     clk,
    input  wire                     rst,
    lsu_axi_master_if.master        bus
);
    typedef enum logic [2:0] {S_IDLE, S_ERR, S_AR, S_R, S_WR, S_B} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_misaligned;
    logic [1:0]        w_off;
    logic [3:0]        w_strb_base;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_r_hs;
    logic              w_b_hs;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;

    assign w_off        = bus.req_addr_i[1:0];
    assign w_misaligned = (bus.req_size_i == 2'd3) ||
                          (bus.req_size_i == 2'd1 && w_off[0]) ||
                          (bus.req_size_i == 2'd2 && w_off != 2'd0);
    // Response pulse cycle keeps the request port closed as well.
    assign w_accept     = (r_state == S_IDLE) && !r_resp_valid && bus.req_valid_i;
    assign w_aw_hs      = bus.awvalid_o && bus.awready_i;
    assign w_w_hs       = bus.wvalid_o && bus.wready_i;
    assign w_r_hs       = (r_state == S_R) && bus.rvalid_i;
    assign w_b_hs       = (r_state == S_B) && bus.bvalid_i;

    always_comb begin
        w_strb_base = 4'b0000;
        case (bus.req_size_i)
            2'd0:    w_strb_base = 4'b0001;
            2'd1:    w_strb_base = 4'b0011;
            2'd2:    w_strb_base = 4'b1111;
            default: w_strb_base = 4'b0000;
        endcase
    end

    assign w_shift = bus.rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = bus.rdata_i;
        case (r_size)
            2'd0:    w_load = r_signed ? {{24{w_shift[7]}}, w_shift[7:0]} : {24'h0, w_shift[7:0]};
            2'd1:    w_load = r_signed ? {{16{w_shift[15]}}, w_shift[15:0]} : {16'h0, w_shift[15:0]};
            default: w_load = bus.rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready_o = 1'b0;
        bus.arvalid_o   = 1'b0;
        bus.rready_o    = 1'b0;
        bus.awvalid_o   = 1'b0;
        bus.wvalid_o    = 1'b0;
        bus.bready_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready_o = !r_resp_valid && !rst;
                if (w_accept) begin
                    if (w_misaligned)        w_next = S_ERR;
                    else if (bus.req_we_i)   w_next = S_WR;
                    else                     w_next = S_AR;
                end
            end
            S_ERR: w_next = S_IDLE;
            S_AR: begin
                bus.arvalid_o = 1'b1;
                if (bus.arready_i) w_next = S_R;
            end
            S_R: begin
                bus.rready_o = 1'b1;
                if (bus.rvalid_i) w_next = S_IDLE;
            end
            S_WR: begin
                bus.awvalid_o = !r_aw_done;
                bus.wvalid_o  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_B;
            end
            S_B: begin
                bus.bready_o = 1'b1;
                if (bus.bvalid_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            if (w_accept) begin
                r_addr    <= bus.req_addr_i;
                r_wdata   <= bus.req_wdata_i << {w_off, 3'b000};
                r_wstrb   <= w_strb_base << w_off;
                r_size    <= bus.req_size_i;
                r_signed  <= bus.req_signed_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_misaligned) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_r_hs) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_load;
                r_resp_err   <= (bus.rresp_i != 2'b00);
            end
            if (w_b_hs) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= (bus.bresp_i != 2'b00);
            end
        end
    end

    assign bus.araddr_o     = r_addr;
    assign bus.awaddr_o     = r_addr;
    assign bus.wdata_o      = r_wdata;
    assign bus.wstrb_o      = r_wstrb;
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_rdata_o = r_resp_rdata;
    assign bus.resp_err_o   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
// ============================================================================
// Module  : tb_lsu_axi_master
// Brief   : Directed self-checking bench for lsu_axi_master.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_axi_master;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    lsu_axi_master_if #(.ADDR_W(32)) bus ();

    lsu_axi_master #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn);
        total++;
        if (bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: req_ready=%b want 1", bus.req_ready_o);
        end
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_size_i   = size;
        bus.req_signed_i = sgn;
        tick();
        bus.req_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.req_ready_o !== 1'b0 || bus.arvalid_o !== 1'b0 || bus.awvalid_o !== 1'b0 ||
            bus.wvalid_o !== 1'b0 || bus.rready_o !== 1'b0 || bus.bready_o !== 1'b0 ||
            bus.resp_valid_o !== 1'b0 || bus.resp_rdata_o !== 32'h0 || bus.resp_err_o !== 1'b0 ||
            bus.araddr_o !== 32'h0 || bus.wdata_o !== 32'h0 || bus.wstrb_o !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b ar=%b aw=%b w=%b r=%b b=%b rv=%b rd=%h er=%b addr=%h wd=%h st=%h want all 0",
                     bus.req_ready_o, bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.rready_o, bus.bready_o,
                     bus.resp_valid_o, bus.resp_rdata_o, bus.resp_err_o, bus.araddr_o, bus.wdata_o, bus.wstrb_o);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: req_ready=%b want 1", bus.req_ready_o);
        end
    endtask

    // Early rvalid is held high during the AR phase and must be ignored.
    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] rdata, input logic [1:0] rresp,
                             input int ar_wait, input logic [31:0] exp_data, input logic exp_err);
        issue(1'b0, addr, 32'h0, size, sgn);
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'hBAD0_BAD0;
        for (int c = 0; c <= ar_wait; c++) begin
            bus.arready_i = (c == ar_wait);
            total++;
            if (bus.arvalid_o !== 1'b1 || bus.araddr_o !== addr || bus.rready_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s_ar c%0d: arvalid=%b araddr=%h rready=%b rdy=%b want 1 %h 0 0",
                         name, c, bus.arvalid_o, bus.araddr_o, bus.rready_o, bus.req_ready_o, addr);
            end
            tick();
        end
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b0;
        total++;
        if (bus.rready_o !== 1'b1 || bus.arvalid_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_r: rready=%b arvalid=%b resp_valid=%b want 1 0 0",
                     name, bus.rready_o, bus.arvalid_o, bus.resp_valid_o);
        end
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = rdata;
        bus.rresp_i  = rresp;
        tick();
        bus.rvalid_i = 1'b0;
        bus.rresp_i  = 2'b00;
        total++;
        if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== exp_data || bus.resp_err_o !== exp_err ||
            bus.req_ready_o !== 1'b0 || bus.rready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_resp: valid=%b rdata=%h err=%b rdy=%b rready=%b want 1 %h %b 0 0",
                     name, bus.resp_valid_o, bus.resp_rdata_o, bus.resp_err_o, bus.req_ready_o,
                     bus.rready_o, exp_data, exp_err);
        end
        tick();
        total++;
        if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: resp_valid=%b rdy=%b want 0 1", name, bus.resp_valid_o, bus.req_ready_o);
        end
    endtask

    // w_at / aw_at: cycle (from WR entry) on which each ready is raised for one cycle.
    task automatic test_store(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input int w_at, input int aw_at,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                              input logic [1:0] bresp, input logic exp_err);
        int last;
        last = (w_at > aw_at) ? w_at : aw_at;
        issue(1'b1, addr, wdata, size, 1'b0);
        for (int c = 0; c <= last; c++) begin
            bus.wready_i  = (c == w_at);
            bus.awready_i = (c == aw_at);
            total++;
            if (bus.awvalid_o !== (c <= aw_at) || bus.wvalid_o !== (c <= w_at) ||
                ((c <= aw_at) && bus.awaddr_o !== addr) ||
                ((c <= w_at) && (bus.wdata_o !== exp_wdata || bus.wstrb_o !== exp_strb)) ||
                bus.bready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s_wr c%0d: awvalid=%b wvalid=%b awaddr=%h wdata=%h wstrb=%b bready=%b want %b %b %h %h %b 0",
                         name, c, bus.awvalid_o, bus.wvalid_o, bus.awaddr_o, bus.wdata_o, bus.wstrb_o,
                         bus.bready_o, (c <= aw_at), (c <= w_at), addr, exp_wdata, exp_strb);
            end
            tick();
        end
        bus.wready_i  = 1'b0;
        bus.awready_i = 1'b0;
        total++;
        if (bus.bready_o !== 1'b1 || bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_b: bready=%b awvalid=%b wvalid=%b want 1 0 0",
                     name, bus.bready_o, bus.awvalid_o, bus.wvalid_o);
        end
        bus.bvalid_i = 1'b1;
        bus.bresp_i  = bresp;
        tick();
        bus.bvalid_i = 1'b0;
        bus.bresp_i  = 2'b00;
        total++;
        if (bus.resp_valid_o !== 1'b1 || bus.resp_err_o !== exp_err || bus.resp_rdata_o !== 32'h0 ||
            bus.req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_resp: valid=%b err=%b rdata=%h rdy=%b want 1 %b 0 0",
                     name, bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o, bus.req_ready_o, exp_err);
        end
        tick();
        total++;
        if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_single: resp_valid=%b rdy=%b want 0 1", name, bus.resp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_misaligned(input string name, input logic we, input logic [31:0] addr,
                                   input logic [1:0] size);
        issue(we, addr, 32'hFFFF_FFFF, size, 1'b1);
        total++;
        if (bus.resp_valid_o !== 1'b1 || bus.resp_err_o !== 1'b1 || bus.resp_rdata_o !== 32'h0 ||
            bus.arvalid_o !== 1'b0 || bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_err: valid=%b err=%b rdata=%h ar=%b aw=%b w=%b rdy=%b want 1 1 0 0 0 0 0",
                     name, bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o, bus.arvalid_o,
                     bus.awvalid_o, bus.wvalid_o, bus.req_ready_o);
        end
        tick();
        total++;
        if (bus.resp_valid_o !== 1'b0 || bus.arvalid_o !== 1'b0 || bus.awvalid_o !== 1'b0 ||
            bus.req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_after: valid=%b ar=%b aw=%b rdy=%b want 0 0 0 1",
                     name, bus.resp_valid_o, bus.arvalid_o, bus.awvalid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        total++;
        if (bus.rready_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_r: rready=%b want 1", bus.rready_o);
        end
        rst = 1'b1;
        #2;
        total++;
        if (bus.rready_o !== 1'b0 || bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: rready=%b rdy=%b resp_valid=%b want 0 0 0",
                     bus.rready_o, bus.req_ready_o, bus.resp_valid_o);
        end
        tick();
        rst = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'h1234_5678;
        tick();
        total++;
        if (bus.req_ready_o !== 1'b1 || bus.rready_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_release: rdy=%b rready=%b resp_valid=%b want 1 0 0",
                     bus.req_ready_o, bus.rready_o, bus.resp_valid_o);
        end
        tick();
        bus.rvalid_i = 1'b0;
        total++;
        if (bus.resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_no_resp: resp_valid=%b want 0", bus.resp_valid_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        bus.req_size_i   = 2'd0;
        bus.req_signed_i = 1'b0;
        bus.arready_i    = 1'b0;
        bus.rdata_i      = 32'h0;
        bus.rresp_i      = 2'b00;
        bus.rvalid_i     = 1'b0;
        bus.awready_i    = 1'b0;
        bus.wready_i     = 1'b0;
        bus.bresp_i      = 2'b00;
        bus.bvalid_i     = 1'b0;
        #1;

        test_reset();
        test_load("ld_word",   32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);
        test_load("ld_byte_s", 32'h8000_0003, 2'd0, 1'b1, 32'h8011_2233, 2'b00, 0, 32'hFFFF_FF80, 1'b0);
        test_load("ld_byte_u", 32'h8000_0003, 2'd0, 1'b0, 32'h8011_2233, 2'b00, 0, 32'h0000_0080, 1'b0);
        test_load("ld_half_s", 32'h8000_0002, 2'd1, 1'b1, 32'h8011_2233, 2'b00, 1, 32'hFFFF_8011, 1'b0);
        test_load("ld_half_u", 32'h8000_0000, 2'd1, 1'b0, 32'h8011_A233, 2'b00, 0, 32'h0000_A233, 1'b0);
        test_load("ld_arwait", 32'h8000_0008, 2'd2, 1'b0, 32'h0BAD_F00D, 2'b00, 5, 32'h0BAD_F00D, 1'b0);
        test_load("ld_rresp",  32'h8000_0001, 2'd0, 1'b1, 32'h0000_7F00, 2'b10, 0, 32'h0000_007F, 1'b1);
        test_store("st_half",  32'h8000_0002, 32'h0000_1234, 2'd1, 0, 3, 32'h1234_0000, 4'b1100, 2'b00, 1'b0);
        test_store("st_bresp", 32'h8000_0000, 32'hCAFE_F00D, 2'd2, 0, 0, 32'hCAFE_F00D, 4'b1111, 2'b10, 1'b1);
        test_store("st_byte",  32'h8000_0001, 32'h0000_00A5, 2'd0, 2, 0, 32'h0000_A500, 4'b0010, 2'b00, 1'b0);
        test_misaligned("mis_ld_word", 1'b0, 32'h8000_0001, 2'd2);
        test_misaligned("mis_st_half", 1'b1, 32'h8000_0003, 2'd1);
        test_misaligned("mis_size3",   1'b0, 32'h8000_0000, 2'd3);
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
